aging_tb_port_arbiter: RTL and testbench

Sequential arbiter for port B of the aging table, shared between the connection time-out inspector (requester A) and the connection-table configuration block (requester C). It grants one RAM access per cycle, registers the RAM-side signals, and routes read data back to the requester that issued the read. Configuration has priority; a starvation guard bounds the wait seen by aging. A same-index hazard flag marks aging reads overtaken by a configuration write.

---
 rtl/aging_tb_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_aging_tb_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aging_tb_port_arbiter.sv
// Purpose: arbitrates aging-table port B between aging (A) and configuration (C); optional starvation guard via AGING_ARB_STARVE_EN.
// Latency: combinational grant in cycle N, registered RAM strobe in N+1, read data returned in N+1+RD_LAT.
// Backpressure: a requester holds its request until its one-cycle grant; the loser simply stays pending.
module aging_tb_port_arbiter #(
  parameter int d_agingTb = 9,
  parameter int w_agingTb = 9,
  parameter int RD_LAT    = 1,
  parameter int MAX_WAIT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aging_enable,
  input  logic                 a_req,
  input  logic                 a_wr,
  input  logic [d_agingTb-1:0] a_idx,
  input  logic [w_agingTb-1:0] a_data,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [w_agingTb-1:0] a_rdata,
  output logic                 a_rstale,
  input  logic                 c_req,
  input  logic                 c_wr,
  input  logic [d_agingTb-1:0] c_idx,
  input  logic [w_agingTb-1:0] c_data,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [w_agingTb-1:0] c_rdata,
  output logic [d_agingTb-1:0] ram_addr,
  output logic [w_agingTb-1:0] ram_data,
  output logic                 ram_rden,
  output logic                 ram_wren,
  input  logic [w_agingTb-1:0] ram_q
);

  // Tag travelling alongside an outstanding read until its data appears on ram_q.
  typedef struct packed {
    logic                 vld;
    logic                 ownerC;
    logic                 stale;
    logic [d_agingTb-1:0] idx;
  } rdTag_t;

  logic                 aElig;
  logic                 cElig;
  logic                 aWins;
  logic                 ramOwnerC;
  logic                 cWrNow;
  logic [RD_LAT-1:0]    hit;
  rdTag_t               pipe [RD_LAT];
  rdTag_t               outTag;
  logic [w_agingTb-1:0] aRdataHold;
  logic [w_agingTb-1:0] cRdataHold;

  assign aElig = a_req & aging_enable;
  assign cElig = c_req;

`ifdef AGING_ARB_STARVE_EN
  logic [7:0] starveCnt;
  logic       starved;

  assign starved = (starveCnt == 8'(MAX_WAIT));
  assign aWins   = aElig & (~cElig | starved);

  // Count cycles A has been denied; a grant or a withdrawn A request restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (!aElig || a_gnt) begin
      starveCnt <= '0;
    end else if (!starved) begin
      starveCnt <= starveCnt + 8'd1;
    end
  end
`else
  assign aWins = aElig & ~cElig;
`endif

  // Grants are forced low while reset is held so every output reads 0 in reset.
  assign a_gnt = reset & aWins;
  assign c_gnt = reset & cElig & ~aWins;

  // Register the winner's fields onto the RAM port; address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_rden  <= 1'b0;
      ram_wren  <= 1'b0;
      ramOwnerC <= 1'b0;
    end else begin
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      if (a_gnt) begin
        ram_addr  <= a_idx;
        ram_data  <= a_data;
        ram_wren  <= a_wr;
        ram_rden  <= ~a_wr;
        ramOwnerC <= 1'b0;
      end else if (c_gnt) begin
        ram_addr  <= c_idx;
        ram_data  <= c_data;
        ram_wren  <= c_wr;
        ram_rden  <= ~c_wr;
        ramOwnerC <= 1'b1;
      end
    end
  end

  assign cWrNow = ram_wren & ramOwnerC;

  // Flag every in-flight aging read whose index is being overwritten by configuration right now.
  always_comb begin
    hit = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      hit[i] = cWrNow & pipe[i].vld & ~pipe[i].ownerC & (pipe[i].idx == ram_addr);
    end
  end

  // Return pipeline: one stage per cycle of RAM latency, accumulating the stale flag as it shifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{vld: ram_rden, ownerC: ramOwnerC, stale: 1'b0, idx: ram_addr};
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= '{vld: pipe[i-1].vld, ownerC: pipe[i-1].ownerC,
                     stale: pipe[i-1].stale | hit[i-1], idx: pipe[i-1].idx};
      end
    end
  end

  assign outTag   = pipe[RD_LAT-1];
  assign a_rvalid = outTag.vld & ~outTag.ownerC;
  assign c_rvalid = outTag.vld & outTag.ownerC;
  // A write landing in the capture cycle also counts as overtaking the read.
  assign a_rstale = a_rvalid & (outTag.stale | hit[RD_LAT-1]);
  assign a_rdata  = a_rvalid ? ram_q : aRdataHold;
  assign c_rdata  = c_rvalid ? ram_q : cRdataHold;

  // Capture returned data per owner so each read-data output holds between returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aRdataHold <= '0;
      cRdataHold <= '0;
    end else begin
      if (a_rvalid) aRdataHold <= ram_q;
      if (c_rvalid) cRdataHold <= ram_q;
    end
  end

endmodule

// File: tb/tb_aging_tb_port_arbiter.sv
// Directed bench: two arbiter instances (RD_LAT 1 and 2) share stimulus, each backed by its own RAM model.
module tb_aging_tb_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       aging_enable;
  logic       a_req, a_wr, c_req, c_wr;
  logic [8:0] a_idx, a_data, c_idx, c_data;

  logic       a_gnt1, a_rvalid1, a_rstale1, c_gnt1, c_rvalid1, ram_rden1, ram_wren1;
  logic [8:0] a_rdata1, c_rdata1, ram_addr1, ram_data1, ram_q1;
  logic       a_gnt2, a_rvalid2, a_rstale2, c_gnt2, c_rvalid2, ram_rden2, ram_wren2;
  logic [8:0] a_rdata2, c_rdata2, ram_addr2, ram_data2, ram_q2, q2a;

  logic [8:0] mem1 [512];
  logic [8:0] mem2 [512];

  int nTests = 0;
  int nFails = 0;

  always #5 clk = ~clk;

  aging_tb_port_arbiter #(.d_agingTb(9), .w_agingTb(9), .RD_LAT(1), .MAX_WAIT(8)) dut1 (
    .clk(clk), .reset(reset), .aging_enable(aging_enable),
    .a_req(a_req), .a_wr(a_wr), .a_idx(a_idx), .a_data(a_data), .a_gnt(a_gnt1),
    .a_rvalid(a_rvalid1), .a_rdata(a_rdata1), .a_rstale(a_rstale1),
    .c_req(c_req), .c_wr(c_wr), .c_idx(c_idx), .c_data(c_data), .c_gnt(c_gnt1),
    .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_rden(ram_rden1), .ram_wren(ram_wren1),
    .ram_q(ram_q1));

  aging_tb_port_arbiter #(.d_agingTb(9), .w_agingTb(9), .RD_LAT(2), .MAX_WAIT(8)) dut2 (
    .clk(clk), .reset(reset), .aging_enable(aging_enable),
    .a_req(a_req), .a_wr(a_wr), .a_idx(a_idx), .a_data(a_data), .a_gnt(a_gnt2),
    .a_rvalid(a_rvalid2), .a_rdata(a_rdata2), .a_rstale(a_rstale2),
    .c_req(c_req), .c_wr(c_wr), .c_idx(c_idx), .c_data(c_data), .c_gnt(c_gnt2),
    .c_rvalid(c_rvalid2), .c_rdata(c_rdata2),
    .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_rden(ram_rden2), .ram_wren(ram_wren2),
    .ram_q(ram_q2));

  // RAM models: contents preset to idx ^ 9'h155 (idx 5 holds 9'h0AB) while reset is low.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) begin
        mem1[i] <= (i == 5) ? 9'h0AB : (9'(i) ^ 9'h155);
        mem2[i] <= (i == 5) ? 9'h0AB : (9'(i) ^ 9'h155);
      end
    end else begin
      if (ram_wren1) mem1[ram_addr1] <= ram_data1;
      if (ram_wren2) mem2[ram_addr2] <= ram_data2;
    end
    ram_q1 <= mem1[ram_addr1];
    q2a    <= mem2[ram_addr2];
    ram_q2 <= q2a;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0;
    c_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b0; aging_enable = 1'b1;
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd3; a_data = 9'd0;
    c_req = 1'b1; c_wr = 1'b0; c_idx = 9'd4; c_data = 9'd0;
    step(); step();
    @(negedge clk);
    nTests++; if ({a_gnt1, c_gnt1, a_gnt2, c_gnt2} !== 4'b0) begin nFails++;
      $display("FAIL reset_gnt: got %b want 0000", {a_gnt1, c_gnt1, a_gnt2, c_gnt2}); end
    nTests++; if ({a_rvalid1, a_rdata1, a_rstale1, c_rvalid1, c_rdata1, ram_addr1, ram_data1, ram_rden1, ram_wren1} !== 43'd0) begin nFails++;
      $display("FAIL reset_outs1: got %h want 0", {a_rvalid1, a_rdata1, a_rstale1, c_rvalid1, c_rdata1, ram_addr1, ram_data1, ram_rden1, ram_wren1}); end
    nTests++; if ({a_rvalid2, a_rdata2, a_rstale2, c_rvalid2, c_rdata2, ram_addr2, ram_data2, ram_rden2, ram_wren2} !== 43'd0) begin nFails++;
      $display("FAIL reset_outs2: got %h want 0", {a_rvalid2, a_rdata2, a_rstale2, c_rvalid2, c_rdata2, ram_addr2, ram_data2, ram_rden2, ram_wren2}); end
    a_req = 1'b0; c_req = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_basic_read();
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd5;
    @(negedge clk);
    nTests++; if ({a_gnt1, c_gnt1} !== 2'b10) begin nFails++; $display("FAIL basic_gnt: got %b want 10", {a_gnt1, c_gnt1}); end
    step(); a_req = 1'b0;
    @(negedge clk);
    nTests++; if ({ram_rden1, ram_wren1, ram_addr1} !== {2'b10, 9'd5}) begin nFails++;
      $display("FAIL basic_strobe: got rden=%b wren=%b addr=%0d want 1 0 5", ram_rden1, ram_wren1, ram_addr1); end
    step();
    @(negedge clk);
    nTests++; if ({a_rvalid1, a_rstale1, c_rvalid1} !== 3'b100) begin nFails++;
      $display("FAIL basic_rvalid: got rvalid=%b stale=%b c_rvalid=%b want 1 0 0", a_rvalid1, a_rstale1, c_rvalid1); end
    nTests++; if (a_rdata1 !== 9'h0AB) begin nFails++; $display("FAIL basic_rdata: got %h want 0ab", a_rdata1); end
    step();
    @(negedge clk);
    nTests++; if ({a_rvalid1, a_rdata1} !== {1'b0, 9'h0AB}) begin nFails++;
      $display("FAIL basic_hold: got rvalid=%b rdata=%h want 0 0ab", a_rvalid1, a_rdata1); end
    idle(4);
  endtask

  task automatic test_starvation();
    logic expA;
    c_req = 1'b1; c_wr = 1'b0; c_idx = 9'd1;
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd2;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
`ifdef AGING_ARB_STARVE_EN
      expA = ((t % 9) == 8);
`else
      expA = 1'b0;
`endif
      nTests++; if ({a_gnt1, c_gnt1} !== {expA, ~expA}) begin nFails++;
        $display("FAIL starve_gnt t=%0d: got a=%b c=%b want a=%b c=%b", t, a_gnt1, c_gnt1, expA, ~expA); end
      step();
    end
    idle(6);
  endtask

  task automatic test_stale();
    // Round 1: C overwrites idx 7 right behind the aging read.
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd7;
    @(negedge clk);
    nTests++; if (a_gnt2 !== 1'b1) begin nFails++; $display("FAIL stale_agnt: got %b want 1", a_gnt2); end
    step(); a_req = 1'b0;
    c_req = 1'b1; c_wr = 1'b1; c_idx = 9'd7; c_data = 9'h1C7;
    @(negedge clk);
    nTests++; if (c_gnt2 !== 1'b1) begin nFails++; $display("FAIL stale_cgnt: got %b want 1", c_gnt2); end
    step(); c_req = 1'b0;
    @(negedge clk);
    nTests++; if ({a_rvalid1, a_rstale1, a_rdata1} !== {2'b11, 9'h152}) begin nFails++;
      $display("FAIL stale_capture_lat1: got rvalid=%b stale=%b rdata=%h want 1 1 152", a_rvalid1, a_rstale1, a_rdata1); end
    step();
    @(negedge clk);
    nTests++; if ({a_rvalid2, a_rstale2, a_rdata2} !== {2'b11, 9'h152}) begin nFails++;
      $display("FAIL stale_inflight_lat2: got rvalid=%b stale=%b rdata=%h want 1 1 152", a_rvalid2, a_rstale2, a_rdata2); end
    idle(4);
    // Round 2: C writes a different index, so the read is clean and sees the round-1 data.
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd7;
    step(); a_req = 1'b0;
    c_req = 1'b1; c_wr = 1'b1; c_idx = 9'd8; c_data = 9'h0E8;
    step(); c_req = 1'b0;
    @(negedge clk);
    nTests++; if ({a_rvalid1, a_rstale1, a_rdata1} !== {2'b10, 9'h1C7}) begin nFails++;
      $display("FAIL nostale_lat1: got rvalid=%b stale=%b rdata=%h want 1 0 1c7", a_rvalid1, a_rstale1, a_rdata1); end
    step();
    @(negedge clk);
    nTests++; if ({a_rvalid2, a_rstale2, a_rdata2} !== {2'b10, 9'h1C7}) begin nFails++;
      $display("FAIL nostale_lat2: got rvalid=%b stale=%b rdata=%h want 1 0 1c7", a_rvalid2, a_rstale2, a_rdata2); end
    idle(4);
    // C reads back idx 8.
    c_req = 1'b1; c_wr = 1'b0; c_idx = 9'd8;
    step(); c_req = 1'b0;
    step();
    @(negedge clk);
    nTests++; if ({c_rvalid1, a_rvalid1, c_rdata1} !== {2'b10, 9'h0E8}) begin nFails++;
      $display("FAIL c_readback: got c_rvalid=%b a_rvalid=%b rdata=%h want 1 0 0e8", c_rvalid1, a_rvalid1, c_rdata1); end
    idle(4);
  endtask

  task automatic test_back_to_back();
    int   k;
    logic expA;
    logic [8:0] expD;
    for (int t = 0; t < 20; t++) begin
      if (t < 16) begin
        c_req = (t % 2 == 0); c_wr = 1'b0; c_idx = 9'(16 + t);
        a_req = (t % 2 == 1); a_wr = 1'b0; a_idx = 9'(16 + t);
      end else begin
        c_req = 1'b0; a_req = 1'b0;
      end
      @(negedge clk);
      if (t >= 1 && t <= 16) begin
        nTests++; if ({ram_rden2, ram_wren2, ram_addr2} !== {2'b10, 9'(16 + t - 1)}) begin nFails++;
          $display("FAIL b2b_strobe t=%0d: got rden=%b wren=%b addr=%0d want 1 0 %0d", t, ram_rden2, ram_wren2, ram_addr2, 16 + t - 1); end
      end
      if (t >= 3 && t <= 18) begin
        k    = t - 3;
        expA = (k % 2 == 1);
        expD = 9'(16 + k) ^ 9'h155;
        nTests++; if ({a_rvalid2, c_rvalid2, (expA ? a_rdata2 : c_rdata2)} !== {expA, ~expA, expD}) begin nFails++;
          $display("FAIL b2b_return t=%0d: got a_rvalid=%b c_rvalid=%b a_rdata=%h c_rdata=%h want a=%b c=%b data=%h",
                   t, a_rvalid2, c_rvalid2, a_rdata2, c_rdata2, expA, ~expA, expD); end
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_enable_off();
    logic expA;
    aging_enable = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd9; c_req = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      nTests++; if ({a_gnt1, a_gnt2, c_gnt1, ram_rden1, ram_wren1, ram_rden2, ram_wren2} !== 7'b0) begin nFails++;
        $display("FAIL disabled_idle t=%0d: got gnt=%b%b%b ram=%b%b%b%b want all 0", t, a_gnt1, a_gnt2, c_gnt1,
                 ram_rden1, ram_wren1, ram_rden2, ram_wren2); end
      step();
    end
    // Build up denial, drop enable for one cycle, then the wait must restart from zero.
    aging_enable = 1'b1; c_req = 1'b1; c_wr = 1'b0; c_idx = 9'd10;
    repeat (5) step();
    aging_enable = 1'b0;
    @(negedge clk);
    nTests++; if ({a_gnt1, c_gnt1} !== 2'b01) begin nFails++; $display("FAIL disable_mid: got a=%b c=%b want 0 1", a_gnt1, c_gnt1); end
    step();
    aging_enable = 1'b1;
    for (int q = 0; q < 10; q++) begin
      @(negedge clk);
`ifdef AGING_ARB_STARVE_EN
      expA = (q == 8);
`else
      expA = 1'b0;
`endif
      nTests++; if (a_gnt1 !== expA) begin nFails++; $display("FAIL reenable_gnt q=%0d: got %b want %b", q, a_gnt1, expA); end
      step();
    end
    idle(6);
  endtask

  task automatic test_reset_midflight();
    a_req = 1'b1; a_wr = 1'b0; a_idx = 9'd5;
    step(); a_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    nTests++; if ({a_rvalid1, a_rdata1, a_rstale1, c_rvalid1, c_rdata1, ram_addr1, ram_data1, ram_rden1, ram_wren1, a_gnt1, c_gnt1} !== 45'd0) begin nFails++;
      $display("FAIL midreset_outs1: got %h want 0", {a_rvalid1, a_rdata1, a_rstale1, c_rvalid1, c_rdata1, ram_addr1, ram_data1, ram_rden1, ram_wren1}); end
    nTests++; if ({a_rvalid2, a_rdata2, a_rstale2, c_rvalid2, c_rdata2, ram_addr2, ram_data2, ram_rden2, ram_wren2, a_gnt2, c_gnt2} !== 45'd0) begin nFails++;
      $display("FAIL midreset_outs2: got %h want 0", {a_rvalid2, a_rdata2, a_rstale2, c_rvalid2, c_rdata2, ram_addr2, ram_data2, ram_rden2, ram_wren2}); end
    step();
    reset = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      nTests++; if ({a_rvalid1, a_rvalid2, c_rvalid1, c_rvalid2} !== 4'b0) begin nFails++;
        $display("FAIL midreset_norvalid t=%0d: got %b want 0000", t, {a_rvalid1, a_rvalid2, c_rvalid1, c_rvalid2}); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_starvation();
    test_stale();
    test_back_to_back();
    test_enable_off();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
